// File: rtl/cache_req_sched_if.sv
// Handshake and status bundle between the trace front end, the cache lookup
// path and the request scheduler.
interface cache_req_sched_if #(
  parameter int CNT_W = 32
);
  logic             i_valid;
  logic             i_ready;
  logic [31:0]      i_addr;
  logic             d_valid;
  logic             d_ready;
  logic [3:0]       d_cmd;
  logic [31:0]      d_addr;
  logic             c_req_valid;
  logic             c_req_ready;
  logic [3:0]       c_cmd;
  logic [31:0]      c_addr;
  logic             c_rsp_valid;
  logic             c_rsp_hit;
  logic             stat_dump;
  logic             err;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  // Front end and cache side
  modport master (
    output i_valid, i_addr, d_valid, d_cmd, d_addr,
    output c_req_ready, c_rsp_valid, c_rsp_hit,
    input  i_ready, d_ready, c_req_valid, c_cmd, c_addr,
    input  stat_dump, err, rd_cnt, wr_cnt, hit_cnt, miss_cnt
  );

  // Scheduler side
  modport slave (
    input  i_valid, i_addr, d_valid, d_cmd, d_addr,
    input  c_req_ready, c_rsp_valid, c_rsp_hit,
    output i_ready, d_ready, c_req_valid, c_cmd, c_addr,
    output stat_dump, err, rd_cnt, wr_cnt, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_req_sched.sv
// Round-robin scheduler of I-fetch / data trace commands onto the cache lookup
// path. Statistics counters are built only when CACHE_SCHED_STATS_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | granted port sees ready; command captured on accept
// S_ISSUE | c_req_valid high with captured cmd/addr until c_req_ready
// S_WAIT  | waiting for c_rsp_valid, bounded by the timeout down-counter
// S_LOCAL | one-cycle handling of print / illegal commands
module cache_req_sched #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  cache_req_sched_if.slave bus
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_ISSUE  = 2'd1;
  localparam logic [1:0]  S_WAIT   = 2'd2;
  localparam logic [1:0]  S_LOCAL  = 2'd3;
  localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic        prio_d;
  logic [3:0]  cmd_q;
  logic [31:0] addr_q;
  logic [15:0] tmr;
  logic        dump_q;
  logic        err_q;

  logic        idle;
  logic        pick_d;
  logic        accept_d;
  logic        accept_i;
  logic [3:0]  acc_cmd;
  logic [31:0] acc_addr;
  logic        acc_illegal;

  function automatic logic is_illegal(input logic [3:0] c);
    case (c)
      4'd5, 4'd6, 4'd7: return 1'b1;
      default:          return (c >= 4'd10);
    endcase
  endfunction

  // The preferred port owns ready unless it is quiet and the other one waits.
  always_comb begin
    idle        = (state == S_IDLE) && !rst;
    pick_d      = prio_d ? (bus.d_valid || !bus.i_valid)
                         : (bus.d_valid && !bus.i_valid);
    accept_d    = idle && pick_d && bus.d_valid;
    accept_i    = idle && !pick_d && bus.i_valid;
    acc_cmd     = accept_d ? bus.d_cmd : 4'd2;
    acc_addr    = accept_d ? bus.d_addr : bus.i_addr;
    acc_illegal = is_illegal(acc_cmd);
  end

  assign bus.d_ready     = idle && pick_d;
  assign bus.i_ready     = idle && !pick_d;
  assign bus.c_req_valid = (state == S_ISSUE);
  assign bus.c_cmd       = cmd_q;
  assign bus.c_addr      = addr_q;
  assign bus.stat_dump   = dump_q;
  assign bus.err         = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      prio_d <= 1'b1;
      cmd_q  <= '0;
      addr_q <= '0;
      tmr    <= '0;
      dump_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      dump_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept_d || accept_i) begin
            cmd_q  <= acc_cmd;
            addr_q <= acc_addr;
            prio_d <= accept_i;
            if (acc_cmd == 4'd9 || acc_illegal) begin
              state  <= S_LOCAL;
              dump_q <= (acc_cmd == 4'd9);
              err_q  <= acc_illegal;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (bus.c_req_ready) begin
            state <= S_WAIT;
            tmr   <= TMR_LOAD;
          end
        end
        S_WAIT: begin
          // A response in the last allowed cycle still wins over the timeout.
          if (bus.c_rsp_valid) begin
            state <= S_IDLE;
          end else if (tmr == '0) begin
            state <= S_IDLE;
            err_q <= 1'b1;
          end else begin
            tmr <= tmr - 16'd1;
          end
        end
        S_LOCAL: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CACHE_SCHED_STATS_EN
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic             rsp_done;
  logic             is_rd;
  logic             is_wr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    rsp_done = (state == S_WAIT) && bus.c_rsp_valid;
    is_rd    = (cmd_q == 4'd0) || (cmd_q == 4'd2);
    is_wr    = (cmd_q == 4'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rsp_done) begin
      if (cmd_q == 4'd8) begin
        rd_cnt   <= '0;
        wr_cnt   <= '0;
        hit_cnt  <= '0;
        miss_cnt <= '0;
      end else if (is_rd || is_wr) begin
        if (is_rd)         rd_cnt   <= sat_inc(rd_cnt);
        if (is_wr)         wr_cnt   <= sat_inc(wr_cnt);
        if (bus.c_rsp_hit) hit_cnt  <= sat_inc(hit_cnt);
        else               miss_cnt <= sat_inc(miss_cnt);
      end
    end
  end

  assign bus.rd_cnt   = rd_cnt;
  assign bus.wr_cnt   = wr_cnt;
  assign bus.hit_cnt  = hit_cnt;
  assign bus.miss_cnt = miss_cnt;
`else
  logic unused_hit;
  assign unused_hit   = bus.c_rsp_hit;
  assign bus.rd_cnt   = '0;
  assign bus.wr_cnt   = '0;
  assign bus.hit_cnt  = '0;
  assign bus.miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_req_sched.sv
// Self-checking bench for cache_req_sched: directed scenarios with literal
// expectations plus a randomized run against a transaction-timed model.
module tb_cache_req_sched;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;
  localparam int INF = 32'h7fff_ffff;
`ifdef CACHE_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_req_sched_if #(.CNT_W(CW)) bus ();
  cache_req_sched #(.TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*CW-1:0] ctr(input int a, input int b, input int c, input int d);
    if (STATS) return {CW'(a), CW'(b), CW'(c), CW'(d)};
    return '0;
  endfunction

  function automatic logic [CW-1:0] sat1(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + CW'(1);
  endfunction

  function automatic logic illegal_cmd(input logic [3:0] c);
    return (c inside {4'd5, 4'd6, 4'd7}) || (c >= 4'd10);
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  int          cyc = 0;
  logic        m_rr_d;
  int          m_free_at, m_req_start, m_deadline, m_err_cyc, m_dump_cyc;
  logic        m_req_open, m_wait;
  logic [3:0]  m_cmd;
  logic [31:0] m_addr;
  logic [CW-1:0] m_rd, m_wr, m_hit, m_miss;
  logic [35:0] issue_log[$];
  int          dump_seen = 0;
  int          err_seen = 0;
  logic        idle_e, own_d, e_dr, e_ir, e_crv, took;
  logic [3:0]  a_cmd;
  logic [31:0] a_addr;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("reset_ctl", 64'({bus.i_ready, bus.d_ready, bus.c_req_valid, bus.stat_dump,
                            bus.err, bus.c_cmd}), 64'd0);
      chk("reset_addr", 64'(bus.c_addr), 64'd0);
      chk("reset_cnt", 64'({bus.rd_cnt, bus.wr_cnt, bus.hit_cnt, bus.miss_cnt}), 64'd0);
      m_rr_d = 1'b1; m_free_at = 0; m_req_open = 1'b0; m_wait = 1'b0;
      m_err_cyc = -1; m_dump_cyc = -1; m_rd = '0; m_wr = '0; m_hit = '0; m_miss = '0;
    end else begin
      idle_e = (cyc >= m_free_at);
      own_d  = m_rr_d ? !(!bus.d_valid && bus.i_valid) : (bus.d_valid && !bus.i_valid);
      e_dr   = idle_e && own_d;
      e_ir   = idle_e && !own_d;
      e_crv  = m_req_open && (cyc >= m_req_start);
      chk("ready_pair", 64'({bus.d_ready, bus.i_ready}), 64'({e_dr, e_ir}));
      chk("c_req_valid", 64'(bus.c_req_valid), 64'(e_crv));
      if (e_crv) chk("c_cmd_addr", 64'({bus.c_cmd, bus.c_addr}), 64'({m_cmd, m_addr}));
      chk("err", 64'(bus.err), 64'(cyc == m_err_cyc));
      chk("stat_dump", 64'(bus.stat_dump), 64'(cyc == m_dump_cyc));
      chk("counters", 64'({bus.rd_cnt, bus.wr_cnt, bus.hit_cnt, bus.miss_cnt}),
          STATS ? 64'({m_rd, m_wr, m_hit, m_miss}) : 64'd0);
      if (bus.stat_dump) dump_seen++;
      if (bus.err) err_seen++;
      // outstanding command resolves by response or by timeout
      if (m_wait && bus.c_rsp_valid) begin
        m_wait = 1'b0; m_free_at = cyc + 1;
        if (m_cmd == 4'd8) begin
          m_rd = '0; m_wr = '0; m_hit = '0; m_miss = '0;
        end else if (m_cmd <= 4'd2) begin
          if (m_cmd != 4'd1) m_rd = sat1(m_rd);
          else               m_wr = sat1(m_wr);
          if (bus.c_rsp_hit) m_hit = sat1(m_hit);
          else               m_miss = sat1(m_miss);
        end
      end else if (m_wait && cyc == m_deadline) begin
        m_wait = 1'b0; m_free_at = cyc + 1; m_err_cyc = cyc + 1;
      end
      if (e_crv && bus.c_req_ready) begin
        issue_log.push_back({m_cmd, m_addr});
        m_req_open = 1'b0; m_wait = 1'b1; m_deadline = cyc + TO;
      end
      took = 1'b0;
      if (e_dr && bus.d_valid) begin
        took = 1'b1; a_cmd = bus.d_cmd; a_addr = bus.d_addr; m_rr_d = 1'b0;
      end else if (e_ir && bus.i_valid) begin
        took = 1'b1; a_cmd = 4'd2; a_addr = bus.i_addr; m_rr_d = 1'b1;
      end
      if (took) begin
        if (a_cmd == 4'd9 || illegal_cmd(a_cmd)) begin
          if (a_cmd == 4'd9) m_dump_cyc = cyc + 1;
          else               m_err_cyc = cyc + 1;
          m_free_at = cyc + 2;
        end else begin
          m_cmd = a_cmd; m_addr = a_addr; m_req_open = 1'b1;
          m_req_start = cyc + 1; m_free_at = INF;
        end
      end
    end
  end

  // ---------------- cache responder ----------------
  int   resp_mode = 1;   // 0 random, 1 answer next cycle, 2 never answer, 4 stray responses
  logic resp_hit = 1'b1;
  logic hs;
  always begin
    @(negedge clk);
    hs = bus.c_req_valid && bus.c_req_ready;
    @(posedge clk);
    #2;
    case (resp_mode)
      0: begin
        bus.c_req_ready = 1'($urandom % 2);
        bus.c_rsp_valid = ($urandom % 3) == 0;
        bus.c_rsp_hit   = 1'($urandom % 2);
      end
      1: begin bus.c_req_ready = 1'b1; bus.c_rsp_valid = hs; bus.c_rsp_hit = resp_hit; end
      2: begin bus.c_req_ready = 1'b1; bus.c_rsp_valid = 1'b0; bus.c_rsp_hit = 1'b0; end
      default: begin bus.c_req_ready = 1'b0; bus.c_rsp_valid = 1'b1; bus.c_rsp_hit = 1'b1; end
    endcase
  end

  // ---------------- stimulus ----------------
  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    settle(2);
    rst = 1'b0;
  endtask

  task automatic send_d(input logic [3:0] cmd, input logic [31:0] addr);
    logic done = 1'b0;
    bus.d_valid = 1'b1; bus.d_cmd = cmd; bus.d_addr = addr;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      done = bus.d_ready;
      @(posedge clk);
      #1;
    end
    bus.d_valid = 1'b0;
    chk("send_accept", 64'(done), 64'd1);
  endtask

  function automatic logic [3:0] pick_cmd();
    case ($urandom % 8)
      0: return 4'd0;
      1: return 4'd1;
      2: return 4'd2;
      3: return 4'd3;
      4: return 4'd4;
      5: return 4'd8;
      6: return 4'd9;
      default: return 4'($urandom % 16);
    endcase
  endfunction

  logic [35:0] exp_ord[4] = '{{4'd1, 32'h200}, {4'd2, 32'h100}, {4'd1, 32'h200}, {4'd2, 32'h100}};
  int  nb, nacc, nd, ne, ni;
  logic ad, ai;

  initial begin
    bus.i_valid = 0; bus.i_addr = 0; bus.d_valid = 0; bus.d_cmd = 0; bus.d_addr = 0;
    bus.c_req_ready = 0; bus.c_rsp_valid = 0; bus.c_rsp_hit = 0;
    settle(3);
    rst = 1'b0;

    // data read hit
    resp_mode = 1; resp_hit = 1'b1;
    send_d(4'd0, 32'h0000_1A40);
    settle(3);
    chk("t1_issue", 64'(issue_log[issue_log.size()-1]), 64'({4'd0, 32'h0000_1A40}));
    chk("t1_cnt", 64'({bus.rd_cnt, bus.wr_cnt, bus.hit_cnt, bus.miss_cnt}), 64'(ctr(1, 0, 1, 0)));

    // simultaneous requests held from reset, all misses
    rst = 1'b1; resp_hit = 1'b0;
    bus.i_valid = 1; bus.i_addr = 32'h100; bus.d_valid = 1; bus.d_cmd = 4'd1; bus.d_addr = 32'h200;
    settle(2);
    nb = issue_log.size(); nacc = 0;
    rst = 1'b0;
    for (int k = 0; k < 60 && nacc < 4; k++) begin
      @(negedge clk);
      nacc += int'(bus.d_valid && bus.d_ready) + int'(bus.i_valid && bus.i_ready);
      @(posedge clk);
      #1;
    end
    bus.i_valid = 0; bus.d_valid = 0;
    chk("t2_accepts", 64'(nacc), 64'd4);
    settle(4);
    chk("t2_issues", 64'(issue_log.size() - nb), 64'd4);
    for (int k = 0; k < 4; k++)
      if (nb + k < issue_log.size()) chk("t2_order", 64'(issue_log[nb+k]), 64'(exp_ord[k]));
    chk("t2_cnt", 64'({bus.rd_cnt, bus.wr_cnt, bus.hit_cnt, bus.miss_cnt}), 64'(ctr(2, 2, 0, 4)));

    // local commands
    nd = dump_seen; ne = err_seen; ni = issue_log.size();
    send_d(4'd9, 32'h0);
    settle(3);
    chk("t3_dump", 64'(dump_seen - nd), 64'd1);
    send_d(4'd6, 32'h44);
    settle(3);
    chk("t3_err", 64'(err_seen - ne), 64'd1);
    chk("t3_no_issue", 64'(issue_log.size() - ni), 64'd0);

    // clear
    do_reset();
    resp_hit = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_d(4'd0, 32'h1000 + 32'(k));
      settle(3);
    end
    chk("t4_pre", 64'({bus.rd_cnt, bus.wr_cnt, bus.hit_cnt, bus.miss_cnt}), 64'(ctr(3, 0, 3, 0)));
    send_d(4'd8, 32'h0);
    settle(3);
    chk("t4_clear", 64'({bus.rd_cnt, bus.wr_cnt, bus.hit_cnt, bus.miss_cnt}), 64'd0);
    resp_hit = 1'b0;
    send_d(4'd0, 32'h2000);
    settle(3);
    chk("t4_post", 64'({bus.rd_cnt, bus.wr_cnt, bus.hit_cnt, bus.miss_cnt}), 64'(ctr(1, 0, 0, 1)));

    // timeout
    resp_mode = 2; ne = err_seen;
    send_d(4'd0, 32'h3000);
    settle(TO + 3);
    chk("t5_err", 64'(err_seen - ne), 64'd1);
    chk("t5_cnt", 64'({bus.rd_cnt, bus.wr_cnt, bus.hit_cnt, bus.miss_cnt}), 64'(ctr(1, 0, 0, 1)));
    resp_mode = 1; resp_hit = 1'b1;
    send_d(4'd1, 32'h3004);
    settle(3);
    chk("t5_next", 64'({bus.rd_cnt, bus.wr_cnt, bus.hit_cnt, bus.miss_cnt}), 64'(ctr(1, 1, 1, 1)));

    // reset while waiting, then stray responses
    resp_mode = 2;
    send_d(4'd0, 32'h4000);
    settle(2);
    #2 rst = 1'b1;
    #1;
    chk("t6_req", 64'(bus.c_req_valid), 64'd0);
    chk("t6_cnt", 64'({bus.rd_cnt, bus.wr_cnt, bus.hit_cnt, bus.miss_cnt}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    resp_mode = 4;
    settle(4);
    chk("t6_stray", 64'({bus.rd_cnt, bus.wr_cnt, bus.hit_cnt, bus.miss_cnt}), 64'd0);

    // randomized traffic, checked cycle by cycle by the model
    resp_mode = 0;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      ad = bus.d_valid && bus.d_ready;
      ai = bus.i_valid && bus.i_ready;
      @(posedge clk);
      #1;
      if (ad || !bus.d_valid) begin
        bus.d_valid = ($urandom % 3) != 0;
        bus.d_cmd   = pick_cmd();
        bus.d_addr  = $urandom;
      end
      if (ai || !bus.i_valid) begin
        bus.i_valid = ($urandom % 3) != 0;
        bus.i_addr  = $urandom;
      end
    end
    bus.d_valid = 0; bus.i_valid = 0;
    settle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
